// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types, state LED encodings and width helpers for the
//               lap stopwatch core.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // Top-level operating states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    // One-hot state indicator values
    localparam logic [2:0] LED_IDLE  = 3'b100;
    localparam logic [2:0] LED_RUN   = 3'b010;
    localparam logic [2:0] LED_PAUSE = 3'b001;

    // Width of a counter holding 0..max_count
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    // Width of a lap index holding 0..depth
    function automatic int lap_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Map a state onto its one-hot indicator
    function automatic logic [2:0] state_to_led(input state_t s);
        logic [2:0] led;
        case (s)
            ST_RUN:   led = LED_RUN;
            ST_PAUSE: led = LED_PAUSE;
            default:  led = LED_IDLE;
        endcase
        return led;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_press_classifier.sv
`default_nettype none
// ============================================================================
// Module      : key_press_classifier
// Description : Synchronises an active-low key, measures how many ticks it is
//               held, and emits one-cycle short/long press pulses on tick
//               cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module key_press_classifier #(
    parameter int LONG_TICKS = 100,
    parameter int DEB_TICKS  = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_n,
    input  logic tick,
    output logic short_pulse,
    output logic long_pulse
);

    localparam int HOLD_W = (LONG_TICKS < 1) ? 1 : $clog2(LONG_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_DEB = HOLD_W'(DEB_TICKS);

    logic [1:0]        sync_q;
    logic [1:0]        sync_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              pressed;

    // Next-state: shift the synchroniser and update the hold count on ticks
    always_comb begin
        sync_d      = {sync_q[0], key_n};
        pressed     = ~sync_q[1];
        hold_d      = hold_q;
        short_pulse = 1'b0;
        long_pulse  = 1'b0;
        if (tick) begin
            if (pressed) begin
                // Count saturates at the long threshold so the long pulse fires once
                if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                    if (hold_d == HOLD_MAX) begin
                        long_pulse = 1'b1;
                    end
                end
            end else begin
                // A release after a long press is silent
                if ((hold_q >= HOLD_DEB) && (hold_q != HOLD_MAX)) begin
                    short_pulse = 1'b1;
                end
                hold_d = '0;
            end
        end
    end

    // Registers: idle key reads as released (high)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= 2'b11;
            hold_q <= '0;
        end else begin
            sync_q <= sync_d;
            hold_q <= hold_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lap_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : lap_stopwatch
// Description : Centisecond stopwatch with short/long key handling, a lap
//               ring buffer and a saturate-or-wrap policy at full scale.
// Revision    : 1.0 - initial release
// ============================================================================
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 500_000,
    parameter int MAX_COUNT  = 5999,
    parameter int LAP_DEPTH  = 9,
    parameter int LONG_TICKS = 100,
    parameter int DEB_TICKS  = 2,
    parameter int WRAP_MODE  = 0,
    localparam int CNT_W     = cnt_width(MAX_COUNT),
    localparam int LAP_W     = lap_width(LAP_DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             KeyA,
    input  logic             KeyB,
    output logic             tick,
    output logic [CNT_W-1:0] cur_time,
    output logic [CNT_W-1:0] lap_time,
    output logic [LAP_W-1:0] lap_total,
    output logic [LAP_W-1:0] lap_sel,
    output logic             overflow,
    output logic [2:0]       state_led
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PTR_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);
    localparam logic [LAP_W-1:0] LAP_FULL = LAP_W'(LAP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LAP_DEPTH - 1);

    // ------------------------------------------------------------------
    // Tick divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_w;

    // Free-running divider; tick marks the last count of each period
    always_comb begin
        tick_w = (div_q == DIV_LAST);
        div_d  = tick_w ? '0 : div_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Key classifiers
    // ------------------------------------------------------------------
    logic a_short;
    logic a_long;
    logic b_short;
    logic b_long;

    key_press_classifier #(
        .LONG_TICKS (LONG_TICKS),
        .DEB_TICKS  (DEB_TICKS)
    ) u_key_a (
        .clk         (clk),
        .rstn        (rstn),
        .key_n       (KeyA),
        .tick        (tick_w),
        .short_pulse (a_short),
        .long_pulse  (a_long)
    );

    key_press_classifier #(
        .LONG_TICKS (LONG_TICKS),
        .DEB_TICKS  (DEB_TICKS)
    ) u_key_b (
        .clk         (clk),
        .rstn        (rstn),
        .key_n       (KeyB),
        .tick        (tick_w),
        .short_pulse (b_short),
        .long_pulse  (b_long)
    );

    // ------------------------------------------------------------------
    // FSM, count and lap bookkeeping
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [2:0]       led_q;
    logic [2:0]       led_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [LAP_W-1:0] sel_q;
    logic [LAP_W-1:0] sel_d;
    logic [LAP_W-1:0] total_q;
    logic [LAP_W-1:0] total_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [CNT_W-1:0] lap_time_q;
    logic [CNT_W-1:0] lap_time_d;
    logic             lap_we;
    logic             a_evt;
    logic             b_short_v;
    logic             b_long_v;
    logic             at_max;

    logic [CNT_W-1:0] lap_mem_q [LAP_DEPTH];

    // Next-state logic: any A event suppresses B events in the same cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sel_d     = sel_q;
        total_d   = total_q;
        wr_ptr_d  = wr_ptr_q;
        lap_we    = 1'b0;
        a_evt     = a_short | a_long;
        b_short_v = b_short & ~a_evt;
        b_long_v  = b_long & ~a_evt;
        at_max    = (cnt_q == CNT_MAX);

        unique case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                ovf_d    = 1'b0;
                sel_d    = '0;
                total_d  = '0;
                wr_ptr_d = '0;
                if (a_short) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (tick_w) begin
                    if (at_max) begin
                        ovf_d = 1'b1;
                        if (WRAP_MODE != 0) begin
                            cnt_d = '0;
                        end else begin
                            state_d = ST_PAUSE;
                            sel_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // Store the pre-increment count; full buffer overwrites the oldest
                if (b_short_v) begin
                    lap_we   = 1'b1;
                    wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
                    if (total_q != LAP_FULL) begin
                        total_d = total_q + 1'b1;
                    end
                end
                if (a_long) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    sel_d    = '0;
                    total_d  = '0;
                    wr_ptr_d = '0;
                end else if (a_short) begin
                    state_d = ST_PAUSE;
                    sel_d   = '0;
                end
            end

            ST_PAUSE: begin
                if (a_long) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    sel_d    = '0;
                    total_d  = '0;
                    wr_ptr_d = '0;
                end else if (a_short) begin
                    // A saturated count cannot resume in saturate mode
                    if (!((WRAP_MODE == 0) && at_max)) begin
                        state_d = ST_RUN;
                    end
                end else if (b_short_v) begin
                    sel_d = (sel_q == total_q) ? '0 : sel_q + 1'b1;
                end else if (b_long_v) begin
                    if (total_q != '0) begin
                        sel_d = total_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        led_d = state_to_led(state_d);
    end

    // Lap read mux: record lap_sel counts from the oldest retained entry
    always_comb begin
        int         oldest;
        int         rd_sum;
        logic [PTR_W-1:0] rd_idx;
        oldest     = (total_q == LAP_FULL) ? int'(wr_ptr_q) : 0;
        rd_sum     = 0;
        rd_idx     = '0;
        lap_time_d = '0;
        if (sel_q != '0) begin
            rd_sum = oldest + int'(sel_q) - 1;
            if (rd_sum >= LAP_DEPTH) begin
                rd_sum = rd_sum - LAP_DEPTH;
            end
            rd_idx     = PTR_W'(rd_sum);
            lap_time_d = lap_mem_q[rd_idx];
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q      <= '0;
            state_q    <= ST_IDLE;
            led_q      <= LED_IDLE;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            sel_q      <= '0;
            total_q    <= '0;
            wr_ptr_q   <= '0;
            lap_time_q <= '0;
        end else begin
            div_q      <= div_d;
            state_q    <= state_d;
            led_q      <= led_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            sel_q      <= sel_d;
            total_q    <= total_d;
            wr_ptr_q   <= wr_ptr_d;
            lap_time_q <= lap_time_d;
        end
    end

    // Lap record storage, cleared on reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_mem_q[i] <= '0;
            end
        end else if (lap_we) begin
            lap_mem_q[wr_ptr_q] <= cnt_q;
        end
    end

    assign tick      = tick_w;
    assign cur_time  = cnt_q;
    assign lap_time  = lap_time_q;
    assign lap_total = total_q;
    assign lap_sel   = sel_q;
    assign overflow  = ovf_q;
    assign state_led = led_q;

endmodule
`default_nettype wire
